// File: rtl/dff_with_enable.sv
// dff_with_enable: D flip-flop with a synchronous active-high reset and a load enable.
// The enable is a hold/load mux in the data path, so clk is never gated.
// With WIDTH > 1, each bit acts as its own cell on a shared clk, reset and enable.
module dff_with_enable #(
    parameter int unsigned          WIDTH       = 1,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             enable,
    output logic [WIDTH-1:0] out
);

    // Stop elaboration if the width is zero.
    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("dff_with_enable: WIDTH must be at least 1");
        end
    endgenerate

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_next;

    // Hold/load mux: keep the stored value unless enable is high.
    always_comb begin
        w_next = r_out;
        if (enable) begin
            w_next = in;
        end
    end

    // Storage element. Reset takes priority over a pending load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= RESET_VALUE;
        end else begin
            r_out <= w_next;
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_dff_with_enable.sv
// tb_dff_with_enable: scoreboard bench for a 1-bit and a 64-bit dff_with_enable.
// A reference model computes each expected value when the stimulus is driven.
// The expected value is queued, then popped and compared after the clock edge.
module tb_dff_with_enable;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [0:0]  in1;
    logic [63:0] in64;
    logic [0:0]  out1;
    logic [63:0] out64;

    int unsigned n_vec = 0;
    int unsigned n_mis = 0;

    logic [63:0] q_exp1[$];
    logic [63:0] q_exp64[$];
    logic [0:0]  m1;
    logic [63:0] m64;

    always #5 clk = ~clk;

    dff_with_enable u_dut1 (
        .clk    (clk),
        .reset  (reset),
        .in     (in1),
        .enable (enable),
        .out    (out1)
    );

    dff_with_enable #(.WIDTH(64)) u_dut64 (
        .clk    (clk),
        .reset  (reset),
        .in     (in64),
        .enable (enable),
        .out    (out64)
    );

    // Compare one observed value against its expected value and record the result.
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus on the falling edge and push the model result.
    // After the next rising edge, pop the result and check both instances.
    task automatic apply(input string tag, input logic r, input logic e,
                         input logic d1, input logic [63:0] d64);
        logic [63:0] exp1;
        logic [63:0] exp64;
        @(negedge clk);
        reset  = r;
        enable = e;
        in1    = d1;
        in64   = d64;
        if (r) begin
            m1  = 1'b0;
            m64 = 64'd0;
        end else if (e) begin
            m1  = d1;
            m64 = d64;
        end
        q_exp1.push_back(64'(m1));
        q_exp64.push_back(m64);
        @(posedge clk);
        #1;
        exp1  = q_exp1.pop_front();
        exp64 = q_exp64.pop_front();
        chk({tag, "/w1"},  64'(out1), exp1);
        chk({tag, "/w64"}, out64,     exp64);
    endtask

    // Change enable and the data inputs between edges, then restore them.
    // Both outputs must stay at the model value until the next rising edge.
    task automatic glitch(input string tag);
        logic       s_en;
        logic [0:0] s_d1;
        logic [63:0] s_d64;
        s_en  = enable;
        s_d1  = in1;
        s_d64 = in64;
        enable = ~s_en;
        in1    = ~s_d1;
        in64   = ~s_d64;
        #1;
        chk({tag, "/glitch_w1"},  64'(out1), 64'(m1));
        chk({tag, "/glitch_w64"}, out64,     m64);
        enable = s_en;
        in1    = s_d1;
        in64   = s_d64;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        in1    = 1'b0;
        in64   = 64'd0;
        m1     = 1'b0;
        m64    = 64'd0;

        // Reset is asserted together with a pending load. Reset must win.
        apply("rst_pend", 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);

        // Load sequence. Each new value appears one cycle after it is presented.
        apply("load1", 1'b0, 1'b1, 1'b1, 64'd32);
        apply("load0", 1'b0, 1'b1, 1'b0, 64'd43);
        apply("load1b", 1'b0, 1'b1, 1'b1, 64'hA5A5_0000_FFFF_1234);

        // Hold with enable low while the data inputs toggle. Also change inputs between edges.
        apply("hold0", 1'b0, 1'b0, 1'b0, 64'd5);
        glitch("hold0");
        apply("hold1", 1'b0, 1'b0, 1'b1, 64'd6);
        glitch("hold1");
        apply("hold2", 1'b0, 1'b0, 1'b0, 64'd7);
        glitch("hold2");

        // Reset in the middle of operation, then resume loading.
        apply("rst_mid", 1'b1, 1'b1, 1'b1, 64'd99);
        apply("resume", 1'b0, 1'b1, 1'b1, 64'd43);

        // Reset with enable low. Reset must not depend on enable.
        apply("pre_dis", 1'b0, 1'b0, 1'b0, 64'd0);
        apply("rst_dis", 1'b1, 1'b0, 1'b1, 64'd1);

        // Wide-instance scenario: load 32, then 43, then hold while in=5.
        apply("w_rst", 1'b1, 1'b0, 1'b0, 64'd0);
        apply("w_32", 1'b0, 1'b1, 1'b0, 64'd32);
        apply("w_43", 1'b0, 1'b1, 1'b1, 64'd43);
        apply("w_hold", 1'b0, 1'b0, 1'b0, 64'd5);
        apply("w_hold2", 1'b0, 1'b0, 1'b1, 64'd5);

        // Random traffic with occasional resets.
        for (int i = 0; i < 40; i++) begin
            apply("rand", ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), {$urandom, $urandom});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/dff_with_enable.md
Name: dff_with_enable

Overview:
- Single-bit (by default) D flip-flop with synchronous load-enable.
- Basic storage cell replicated per bit inside the generic `register` block (WIDTH instances, shared clk/reset/enable).
- Holds its value when enable is low; loads `in` on the rising clock edge when enable is high.

Parameters:
- WIDTH, 1, data width in bits. Instances in `register` use the default of 1. Values ≥ 1 are legal; 0 must fail an elaboration-time assertion.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into `out` by reset.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- in  input  WIDTH  data to load.
- enable  input  1  active-high load enable.
- out  output  WIDTH  registered data; driven directly from the storage element.

Behaviour:
- All state changes occur only on the rising edge of clk. There are no asynchronous paths; `out` never changes between edges.
- Priority at each posedge, highest first:
  1. If reset == 1, then out <= RESET_VALUE (0 by default), regardless of enable and in.
  2. Else if enable == 1, then out <= in.
  3. Else out holds its previous value.
- Latency: one cycle. A value on `in` sampled at edge N appears on `out` immediately after edge N.
- Reset value: `out` = RESET_VALUE after the first edge with reset high.
  - Before any reset edge, `out` is unspecified (X in simulation). Users must reset before relying on `out`.
- Reset mid-operation: asserting reset at any edge clears `out` on that edge, even when enable == 1 and in ≠ 0.
  - Deasserting reset resumes normal enable behaviour on the next edge.
- Simultaneous reset and enable: reset wins.
- Enable low for any number of cycles: `out` is stable, and `in` toggling has no effect.
- Enable toggling while clk is stable: no effect until the next rising edge.
- X/Z on in with enable high propagates to out. X on enable or reset is not required to be handled; the bench must keep them driven.
- Implementation:
  - Purely synchronous: one clocked process plus a 2:1 hold/load mux.
  - No latches, no gated clocks.
  - Enable must be implemented as a data-path mux, not by gating clk.
- Per-bit independence when WIDTH > 1: each bit behaves exactly as a WIDTH=1 instance sharing clk/reset/enable.

Test Plan:
- Reset with load pending: reset=1, enable=1, in=1 at edge 0 → out=0 after edge 0 (reset dominates).
- Load: reset=0, enable=1, in=1 at edge 1 → out=1 after edge 1. Then in=0 at edge 2 → out=0. Then in=1 at edge 3 → out=1 (one-cycle latency each time).
- Hold: out=1, enable=0, in toggled 0/1/0 across 3 edges → out stays 1 throughout. Glitching enable and in between edges causes no change.
- Reset mid-operation: out=1, enable=1, in=1, reset pulsed high for one edge → out=0 after that edge. Reset=0 on the next edge with in=1 → out=1.
- Reset while disabled: out=1, enable=0, reset=1 → out=0 (reset does not require enable).
- Wide instance: WIDTH=64, reset → out=0. Then enable=1, in=32 → out=32. Then in=43 → out=43 over 3 edges. Then enable=0 with in=5 → out remains 43.
